// File: rtl/pipe_rc_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit ripple segment per stage,
// valid/ready handshake with a single global stall enable.

module pipe_rc_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_c,
  output logic [SEG-1:0] o_s,
  output logic           o_co,
  output logic           o_cm
);
  logic [SEG:0] w_c;

  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_c;
    for (int i = 0; i < SEG; i++) begin
      o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  // o_cm is the carry into the segment's top bit; only the last stage uses it
  assign o_co = w_c[SEG];
  assign o_cm = w_c[SEG-1];
endmodule

module pipe_rc_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int NSEG = WIDTH / SEG;
  localparam logic [WIDTH-1:0] SMASK = WIDTH'({SEG{1'b1}});

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_param
    $error("pipe_rc_adder: WIDTH must be a positive multiple of SEG");
  end

  logic             w_en;
  logic [WIDTH-1:0] w_bx;
  logic             w_cx;

  logic [NSEG-1:0]            r_vld;
  logic [NSEG-1:0]            r_c;
  logic [NSEG-1:0][WIDTH-1:0] r_a;
  logic [NSEG-1:0][WIDTH-1:0] r_b;
  logic [NSEG-1:0][WIDTH-1:0] r_s;
  logic                       r_cm;

  logic [NSEG-1:0]            w_vin;
  logic [NSEG-1:0][WIDTH-1:0] w_ain;
  logic [NSEG-1:0][WIDTH-1:0] w_bin;
  logic [NSEG-1:0][WIDTH-1:0] w_snx;
  logic [NSEG-1:0]            w_co;
  logic [NSEG-1:0]            w_cm;

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;
  assign w_bx     = sub ? ~b : b;
  assign w_cx     = sub ? ~carry_in : carry_in;

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    logic [SEG-1:0]   w_sa;
    logic [SEG-1:0]   w_sb;
    logic [SEG-1:0]   w_ss;
    logic             w_ci;
    logic [WIDTH-1:0] w_base;

    if (k == 0) begin : g_first
      assign w_vin[k] = in_valid;
      assign w_ain[k] = a;
      assign w_bin[k] = w_bx;
      assign w_sa     = a[SEG-1:0];
      assign w_sb     = w_bx[SEG-1:0];
      assign w_ci     = w_cx;
      assign w_base   = '0;
    end else begin : g_next
      // operand segments arrive skewed: stage k reads what stage k-1 registered
      assign w_vin[k] = r_vld[k-1];
      assign w_ain[k] = r_a[k-1];
      assign w_bin[k] = r_b[k-1];
      assign w_sa     = r_a[k-1][k*SEG +: SEG];
      assign w_sb     = r_b[k-1][k*SEG +: SEG];
      assign w_ci     = r_c[k-1];
      assign w_base   = r_s[k-1];
    end

    pipe_rc_seg #(.SEG(SEG)) u_seg (
      .i_a  (w_sa),
      .i_b  (w_sb),
      .i_c  (w_ci),
      .o_s  (w_ss),
      .o_co (w_co[k]),
      .o_cm (w_cm[k])
    );

    assign w_snx[k] = (w_base & ~(SMASK << (k*SEG))) | (WIDTH'(w_ss) << (k*SEG));
  end

  // One enable for every stage: a stall freezes bubbles in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_c   <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_s   <= '0;
      r_cm  <= 1'b0;
    end else if (w_en) begin
      r_vld <= w_vin;
      r_c   <= w_co;
      r_a   <= w_ain;
      r_b   <= w_bin;
      r_s   <= w_snx;
      r_cm  <= w_cm[NSEG-1];
    end
  end

  assign out_valid = r_vld[NSEG-1];
  assign sum       = r_s[NSEG-1];
  assign carry_out = r_c[NSEG-1];
  assign overflow  = r_cm ^ r_c[NSEG-1];

  logic w_unused;
  assign w_unused = ^{r_a[NSEG-1], r_b[NSEG-1], w_cm};
endmodule

// File: tb/tb_pipe_rc_adder.sv
// Directed and swept checks of pipe_rc_adder: boundary adds/subs, backpressure,
// mid-stream reset, and two alternate WIDTH/SEG configurations.

module tb_pipe_rc_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        d0_iv, d0_ir, d0_ci, d0_sub, d0_ov, d0_or, d0_co, d0_of;
  logic [15:0] d0_a, d0_b, d0_s;
  logic        d1_iv, d1_ir, d1_ci, d1_sub, d1_ov, d1_or, d1_co, d1_of;
  logic [31:0] d1_a, d1_b, d1_s;
  logic        d2_iv, d2_ir, d2_ci, d2_sub, d2_ov, d2_or, d2_co, d2_of;
  logic [7:0]  d2_a, d2_b, d2_s;

  pipe_rc_adder #(.WIDTH(16), .SEG(4)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(d0_iv), .in_ready(d0_ir), .a(d0_a), .b(d0_b),
    .carry_in(d0_ci), .sub(d0_sub), .out_valid(d0_ov), .out_ready(d0_or), .sum(d0_s),
    .carry_out(d0_co), .overflow(d0_of));
  pipe_rc_adder #(.WIDTH(32), .SEG(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_iv), .in_ready(d1_ir), .a(d1_a), .b(d1_b),
    .carry_in(d1_ci), .sub(d1_sub), .out_valid(d1_ov), .out_ready(d1_or), .sum(d1_s),
    .carry_out(d1_co), .overflow(d1_of));
  pipe_rc_adder #(.WIDTH(8), .SEG(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_iv), .in_ready(d2_ir), .a(d2_a), .b(d2_b),
    .carry_in(d2_ci), .sub(d2_sub), .out_valid(d2_ov), .out_ready(d2_or), .sum(d2_s),
    .carry_out(d2_co), .overflow(d2_of));

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        of;
    int          acc;
    int          st;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        of;
  } vec_t;

  vec_t vt[9];
  exp_t q0[$], q1[$], q2[$];
  exp_t x0, x1, x2;
  int   n_chk = 0, n_err = 0, cyc = 0, stalls = 0;
  logic [15:0] e_s;
  logic        e_co, e_of;
  logic        hold_v = 1'b0;
  logic [17:0] hold_val;
  logic [65:0] m1, m2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // reference: {overflow, carry_out, sum} for a w-bit add/sub
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic ci, input logic sub);
    logic [63:0] mask, bx, s;
    logic [64:0] full;
    logic        cx, co, of;
    mask = (64'h1 << w) - 64'h1;
    bx   = (sub ? ~b : b) & mask;
    cx   = sub ? ~ci : ci;
    full = {1'b0, a & mask} + {1'b0, bx} + {64'h0, cx};
    s    = full[63:0] & mask;
    co   = full[w];
    of   = (a[w-1] == bx[w-1]) && (s[w-1] != a[w-1]);
    return {of, co, s};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // d0 scoreboard: order, values, latency (NSEG plus stall cycles), hold stability
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (d0_ov && hold_v) chk("d0_hold", {d0_co, d0_of, d0_s}, hold_val);
      if (d0_ov && !d0_or) begin
        chk("d0_stall_in_ready", d0_ir, 0);
        stalls++;
      end
      hold_v   = d0_ov && !d0_or;
      hold_val = {d0_co, d0_of, d0_s};
      if (d0_iv && d0_ir) q0.push_back('{e_s, e_co, e_of, cyc, stalls});
      if (d0_ov && d0_or) begin
        if (q0.size() == 0) chk("d0_spurious", d0_ov, 0);
        else begin
          x0 = q0.pop_front();
          chk("d0_sum", d0_s, x0.s);
          chk("d0_co", d0_co, x0.co);
          chk("d0_of", d0_of, x0.of);
          chk("d0_lat", cyc - x0.acc, 4 + stalls - x0.st);
        end
      end
    end
  end

  // sweep scoreboards for the alternate configurations
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (d1_iv && d1_ir) begin
        m1 = ref_add(32, 64'(d1_a), 64'(d1_b), d1_ci, d1_sub);
        q1.push_back('{m1[63:0], m1[64], m1[65], cyc, 0});
      end
      if (d1_ov && d1_or) begin
        if (q1.size() == 0) chk("d1_spurious", d1_ov, 0);
        else begin
          x1 = q1.pop_front();
          chk("d1_sum", 64'(d1_s), x1.s);
          chk("d1_co", d1_co, x1.co);
          chk("d1_of", d1_of, x1.of);
          chk("d1_lat", cyc - x1.acc, 4);
        end
      end
      if (d2_iv && d2_ir) begin
        m2 = ref_add(8, 64'(d2_a), 64'(d2_b), d2_ci, d2_sub);
        q2.push_back('{m2[63:0], m2[64], m2[65], cyc, 0});
      end
      if (d2_ov && d2_or) begin
        if (q2.size() == 0) chk("d2_spurious", d2_ov, 0);
        else begin
          x2 = q2.pop_front();
          chk("d2_sum", 64'(d2_s), x2.s);
          chk("d2_co", d2_co, x2.co);
          chk("d2_of", d2_of, x2.of);
          chk("d2_lat", cyc - x2.acc, 1);
        end
      end
    end
  end

  task automatic send0(input vec_t v);
    logic ok;
    int   n;
    d0_a = v.a; d0_b = v.b; d0_ci = v.ci; d0_sub = v.sub;
    e_s = v.s; e_co = v.co; e_of = v.of;
    d0_iv = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = d0_ir;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("d0_accept_timeout", ok, 1);
    d0_iv = 1'b0;
  endtask

  task automatic drain0();
    int n;
    n = 0;
    while (q0.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("d0_drain", q0.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{16'd10,    16'd22,    1'b0, 1'b0, 16'd32,    1'b0, 1'b0};
    vt[1] = '{16'd10,    16'd22,    1'b1, 1'b0, 16'd33,    1'b0, 1'b0};
    vt[2] = '{16'd32768, 16'd65535, 1'b0, 1'b0, 16'd32767, 1'b1, 1'b1};
    vt[3] = '{16'd32767, 16'd32767, 1'b1, 1'b0, 16'd65535, 1'b0, 1'b1};
    vt[4] = '{16'd32768, 16'd32768, 1'b0, 1'b0, 16'd0,     1'b1, 1'b1};
    vt[5] = '{16'd65535, 16'd65535, 1'b0, 1'b0, 16'd65534, 1'b1, 1'b0};
    vt[6] = '{16'd0,     16'd0,     1'b0, 1'b0, 16'd0,     1'b0, 1'b0};
    vt[7] = '{16'd10,    16'd22,    1'b0, 1'b1, 16'd65524, 1'b0, 1'b0};
    vt[8] = '{16'd22,    16'd10,    1'b1, 1'b1, 16'd11,    1'b1, 1'b0};

    rst_n = 1'b0;
    d0_iv = 0; d0_a = 0; d0_b = 0; d0_ci = 0; d0_sub = 0; d0_or = 1;
    d1_iv = 0; d1_a = 0; d1_b = 0; d1_ci = 0; d1_sub = 0; d1_or = 1;
    d2_iv = 0; d2_a = 0; d2_b = 0; d2_ci = 0; d2_sub = 0; d2_or = 1;
    e_s = 0; e_co = 0; e_of = 0;
    #1;
    chk("rst_out_valid", d0_ov, 0);
    chk("rst_sum", d0_s, 0);
    chk("rst_co", d0_co, 0);
    chk("rst_of", d0_of, 0);
    chk("rst_in_ready", d0_ir, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // directed vectors back to back
    for (int i = 0; i < 9; i++) send0(vt[i]);
    drain0();

    // backpressure: out_ready low for 3 cycles while 8 operands stream
    fork
      begin
        repeat (5) @(posedge clk);
        #1 d0_or = 1'b0;
        repeat (3) @(posedge clk);
        #1 d0_or = 1'b1;
      end
    join_none
    for (int i = 0; i < 8; i++) send0(vt[i]);
    drain0();
    chk("bp_stall_cycles", stalls, 3);

    // reset with 3 operations in flight and the head one held at the output
    d0_or = 1'b0;
    for (int i = 0; i < 3; i++) send0(vt[i + 2]);
    @(posedge clk);
    #1;
    chk("rst_pre_valid", d0_ov, 1);
    #2 rst_n = 1'b0;
    q0.delete();
    #1;
    chk("arst_out_valid", d0_ov, 0);
    chk("arst_sum", d0_s, 0);
    chk("arst_co", d0_co, 0);
    chk("arst_of", d0_of, 0);
    chk("arst_in_ready", d0_ir, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    d0_or = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_quiet", d0_ov, 0);
    send0(vt[8]);
    drain0();

    // parameter sweep with random operands and bubbles
    for (int i = 0; i < 60; i++) begin
      d1_a = $urandom(); d1_b = $urandom();
      d1_ci = 1'($urandom_range(0, 1)); d1_sub = 1'($urandom_range(0, 1));
      d1_iv = ($urandom_range(0, 3) != 0);
      d2_a = 8'($urandom()); d2_b = 8'($urandom());
      d2_ci = 1'($urandom_range(0, 1)); d2_sub = 1'($urandom_range(0, 1));
      d2_iv = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    d1_iv = 0; d2_iv = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("d1_drain", q1.size(), 0);
    chk("d2_drain", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
